// File: rtl/conv_window_gen.sv
// Sliding KERNELxKERNEL window generator: turns a raster pixel stream into
// valid-only, stride-1 windows for the convolution stage.
module conv_window_gen #(
  parameter int KERNEL = 3,
  parameter int N      = 8,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N-1:0]                 pix_in,
  input  logic                         pix_en,
  output logic [KERNEL*KERNEL*N-1:0]   data2conv,
  output logic                         en_out,
  output logic                         frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(KERNEL - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(KERNEL - 1);

  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  // A 1x1 kernel has nothing to fill, so it starts directly in RUN.
  localparam logic [0:0] S_INIT = (KERNEL > 1) ? S_FILL : S_RUN;

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [0:0]    r_state;

  logic          w_col_last;
  logic          w_row_last;
  logic          w_col_ok;
  logic          w_emit;
  logic [RW-1:0] w_row_nxt;
  logic [0:0]    w_state_nxt;

  logic [N-1:0]  w_newcol  [KERNEL];
  logic [N-1:0]  w_win_nxt [KERNEL][KERNEL];
  logic [KERNEL*KERNEL*N-1:0] w_pack;

  assign w_col_last = (r_col == COL_LAST);
  assign w_row_last = (r_row == ROW_LAST);
  assign w_row_nxt  = w_row_last ? '0 : r_row + RW'(1);
  assign w_emit     = pix_en && (r_state == S_RUN) && w_col_ok;
  assign w_newcol[KERNEL-1] = pix_in;

  generate
    if (KERNEL > 1) begin : g_buf
      logic [N-1:0] r_lb  [KERNEL-1][IMG_W];
      logic [N-1:0] r_win [KERNEL][KERNEL];

      assign w_col_ok    = (r_col >= COL_FIRST);
      assign w_state_nxt = (w_row_nxt >= ROW_FIRST) ? S_RUN : S_FILL;

      // line_buf[0] holds the row just above pix_in; higher indices are older rows
      for (genvar r = 0; r < KERNEL - 1; r++) begin : g_col
        assign w_newcol[r] = r_lb[KERNEL-2-r][r_col];
      end

      always_ff @(posedge clk) begin
        if (pix_en) begin
          r_lb[0][r_col] <= pix_in;
          for (int k = 1; k < KERNEL - 1; k++) r_lb[k][r_col] <= r_lb[k-1][r_col];
          r_win <= w_win_nxt;
        end
      end

      always_comb begin
        for (int r = 0; r < KERNEL; r++) begin
          for (int c = 0; c < KERNEL - 1; c++) w_win_nxt[r][c] = r_win[r][c+1];
          w_win_nxt[r][KERNEL-1] = w_newcol[r];
        end
      end
    end else begin : g_nobuf
      assign w_col_ok       = 1'b1;
      assign w_state_nxt    = S_RUN;
      assign w_win_nxt[0][0] = w_newcol[0];
    end
  endgenerate

  always_comb begin
    w_pack = '0;
    for (int r = 0; r < KERNEL; r++)
      for (int c = 0; c < KERNEL; c++)
        w_pack[(r*KERNEL+c)*N +: N] = w_win_nxt[r][c];
  end

  // Output stage: window registered one cycle after its bottom-right pixel.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_col      <= '0;
      r_row      <= '0;
      r_state    <= S_INIT;
      en_out     <= 1'b0;
      frame_done <= 1'b0;
      data2conv  <= '0;
    end else begin
      en_out     <= w_emit;
      frame_done <= w_emit && w_col_last && w_row_last;
      if (w_emit) data2conv <= w_pack;
      if (pix_en) begin
        if (w_col_last) begin
          r_col   <= '0;
          r_row   <= w_row_nxt;
          r_state <= w_state_nxt;
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
    end
  end

endmodule
